// File: rtl/kbd_ps2_ctrl.sv
// PS/2 keyboard receiver with a scan-code FIFO behind a small memory-mapped
// register interface (DATA pops on read, STATUS carries count and sticky flags).
module kbd_ps2_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    input  logic        i_sel,
    input  logic        i_re,
    input  logic        i_we,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_dout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (AW + 1 > 8) ? AW + 1 : 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [1:0]      r_ps2ClkSync;
    logic [1:0]      r_ps2DataSync;
    logic            r_ps2ClkPrev;
    logic [2:0]      r_bitCnt;
    logic [7:0]      r_shift;
    logic            r_parityBit;
    logic [TW-1:0]   r_toCnt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_parityErr;
    logic            r_frameErr;

    logic            w_fe;
    logic            w_data;
    logic            w_timeout;
    logic            w_pushReq;
    logic            w_setParity;
    logic            w_setFrame;
    logic            w_pop;
    logic            w_full;
    logic            w_pushOk;
    logic            w_overflowSet;
    logic            w_statusWr;

    assign w_fe   = r_ps2ClkPrev & ~r_ps2ClkSync[1];
    assign w_data = r_ps2DataSync[1];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A falling edge always beats the timeout, so a late edge is never lost.
    always_comb begin
        w_nextState = r_state;
        w_timeout   = 1'b0;
        w_pushReq   = 1'b0;
        w_setParity = 1'b0;
        w_setFrame  = 1'b0;
        if (r_state != IDLE && !w_fe && r_toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_timeout   = 1'b1;
            w_nextState = IDLE;
        end else if (w_fe) begin
            case (r_state)
                IDLE:    if (!w_data) w_nextState = DATA;
                DATA:    if (r_bitCnt == 3'd7) w_nextState = PARITY;
                PARITY:  w_nextState = STOP;
                STOP: begin
                    w_nextState = IDLE;
                    if (!w_data) begin
                        w_setFrame = 1'b1;
                    end else if (!(^{r_shift, r_parityBit})) begin
                        w_setParity = 1'b1;
                    end else begin
                        w_pushReq = 1'b1;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ps2ClkSync  <= 2'b11;
            r_ps2DataSync <= 2'b11;
            r_ps2ClkPrev  <= 1'b1;
            r_bitCnt      <= '0;
            r_shift       <= '0;
            r_parityBit   <= 1'b0;
            r_toCnt       <= '0;
        end else begin
            r_ps2ClkSync  <= {r_ps2ClkSync[0], i_ps2_clk};
            r_ps2DataSync <= {r_ps2DataSync[0], i_ps2_data};
            r_ps2ClkPrev  <= r_ps2ClkSync[1];
            if (r_state == IDLE || w_fe || w_timeout) begin
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + 1'b1;
            end
            if (w_fe) begin
                case (r_state)
                    IDLE:    r_bitCnt <= '0;
                    DATA: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                    end
                    PARITY:  r_parityBit <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign w_pop         = i_sel & i_re & (i_addr[3:2] == 2'b00) & (r_count != '0);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_pushOk      = w_pushReq & (~w_full | w_pop);
    assign w_overflowSet = w_pushReq & w_full & ~w_pop;
    assign w_statusWr    = i_sel & i_we & (i_addr[3:2] == 2'b01);

    always_ff @(posedge i_clk) begin
        if (w_pushOk) begin
            r_mem[r_tail] <= r_shift;
        end
    end

    // When full, push and pop share one slot; the popped byte was already read out.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            if (w_pushOk) r_tail <= r_tail + 1'b1;
            if (w_pop)    r_head <= r_head + 1'b1;
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_overflowSet)                   r_overflow  <= 1'b1;
            else if (w_statusWr && i_wdata[0])   r_overflow  <= 1'b0;
            if (w_setParity)                     r_parityErr <= 1'b1;
            else if (w_statusWr && i_wdata[1])   r_parityErr <= 1'b0;
            if (w_setFrame)                      r_frameErr  <= 1'b1;
            else if (w_statusWr && i_wdata[2])   r_frameErr  <= 1'b0;
        end
    end

    always_comb begin
        o_dout = '0;
        if (i_sel) begin
            case (i_addr[3:2])
                2'b00: if (r_count != '0) o_dout = {23'b0, 1'b1, r_mem[r_head]};
                2'b01: o_dout = {16'b0, r_count[7:0], 5'b0, r_frameErr, r_parityErr, r_overflow};
                default: o_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_ps2_ctrl.sv
// Directed bench for kbd_ps2_ctrl: drives PS/2 frames bit by bit and checks
// the DATA/STATUS registers against hand-computed values.
module tb_kbd_ps2_ctrl;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;

    logic        clk;
    logic        rstn;
    logic        ps2Clk;
    logic        ps2Data;
    logic        sel;
    logic        re;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    kbd_ps2_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_ps2_clk (ps2Clk),
        .i_ps2_data(ps2Data),
        .i_sel     (sel),
        .i_re      (re),
        .i_we      (we),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .o_dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
            $error("[TB] %s observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Sends the first nBits of a frame: start, 8 data LSB first, parity, stop.
    task automatic applyStimulus(input logic [7:0] b, input logic badPar, input logic stopBit, input int nBits);
        logic [10:0] frame;
        frame = {stopBit, (~^b) ^ badPar, b, 1'b0};
        for (int k = 0; k < nBits; k++) begin
            @(negedge clk); ps2Data = frame[k];
            repeat (5) @(negedge clk);
            ps2Clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2Clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        @(negedge clk); ps2Data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic busRead(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; re = 1'b1; addr = a;
        #2 d = dout;
        @(posedge clk);
        #1 sel = 1'b0; re = 1'b0;
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1 sel = 1'b0; we = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1;
        sel = 1'b0; re = 1'b0; we = 1'b0; addr = 4'h0; wdata = '0;
        repeat (5) @(negedge clk);

        busRead(4'h0, rd); checkOutput("data_in_reset", rd, 32'h0000_0000);
        rstn = 1'b1;
        busRead(4'h0, rd); checkOutput("data_after_reset", rd, 32'h0000_0000);
        busRead(4'h4, rd); checkOutput("status_after_reset", rd, 32'h0000_0000);
        busRead(4'h8, rd); checkOutput("reserved_8", rd, 32'h0000_0000);

        applyStimulus(8'h1C, 1'b0, 1'b1, 11);
        busRead(4'h0, rd); checkOutput("single_1c", rd, 32'h0000_011C);
        busRead(4'h0, rd); checkOutput("single_empty", rd, 32'h0000_0000);

        applyStimulus(8'h1C, 1'b0, 1'b1, 11);
        applyStimulus(8'hF0, 1'b0, 1'b1, 11);
        busRead(4'h4, rd); checkOutput("two_count2", rd, 32'h0000_0200);
        sel = 1'b0;
        @(negedge clk); addr = 4'h0; #2 checkOutput("unselected_zero", dout, 32'h0000_0000);
        busRead(4'h0, rd); checkOutput("two_first", rd, 32'h0000_011C);
        busRead(4'h4, rd); checkOutput("two_count1", rd, 32'h0000_0100);
        busRead(4'h0, rd); checkOutput("two_second", rd, 32'h0000_01F0);
        busRead(4'h4, rd); checkOutput("two_count0", rd, 32'h0000_0000);

        applyStimulus(8'h1C, 1'b1, 1'b1, 11);
        busRead(4'h4, rd); checkOutput("parity_err", rd, 32'h0000_0002);
        busRead(4'h0, rd); checkOutput("parity_no_push", rd, 32'h0000_0000);
        busWrite(4'h4, 32'h0000_0002);
        busRead(4'h4, rd); checkOutput("parity_cleared", rd, 32'h0000_0000);

        applyStimulus(8'h1C, 1'b1, 1'b0, 11);
        busRead(4'h4, rd); checkOutput("frame_err_priority", rd, 32'h0000_0004);
        busWrite(4'h4, 32'h0000_0004);
        busRead(4'h4, rd); checkOutput("frame_cleared", rd, 32'h0000_0000);

        for (int i = 0; i < 9; i++) applyStimulus(8'(8'h10 + i), 1'b0, 1'b1, 11);
        busRead(4'h4, rd); checkOutput("full_overflow", rd, 32'h0000_0801);
        for (int i = 0; i < 8; i++) begin
            busRead(4'h0, rd);
            checkOutput($sformatf("fifo_order%0d", i), rd, 32'h0000_0100 | (32'h10 + 32'(i)));
        end
        busRead(4'h0, rd); checkOutput("fifo_drained", rd, 32'h0000_0000);
        busWrite(4'h4, 32'h0000_0001);
        busRead(4'h4, rd); checkOutput("overflow_cleared", rd, 32'h0000_0000);

        applyStimulus(8'h33, 1'b0, 1'b1, 5);
        repeat (TIMEOUT + 20) @(negedge clk);
        applyStimulus(8'h5A, 1'b0, 1'b1, 11);
        busRead(4'h4, rd); checkOutput("timeout_status", rd, 32'h0000_0100);
        busRead(4'h0, rd); checkOutput("timeout_data", rd, 32'h0000_015A);

        applyStimulus(8'h1C, 1'b0, 1'b1, 11);
        applyStimulus(8'h33, 1'b0, 1'b1, 6);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        busRead(4'h4, rd); checkOutput("midreset_status", rd, 32'h0000_0000);
        busRead(4'h0, rd); checkOutput("midreset_data", rd, 32'h0000_0000);
        applyStimulus(8'h66, 1'b0, 1'b1, 11);
        busRead(4'h0, rd); checkOutput("post_reset_frame", rd, 32'h0000_0166);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
